// File: rtl/pot_scan_ctrl_if.sv
// SPI-master handshake between pot_scan_ctrl (master side issues wrt/cmd)
// and the SPI master engine (returns done/rd_data).
interface pot_scan_ctrl_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/pot_scan_ctrl.sv
// Round-robin scanner of the six equalizer pots through one shared SPI A2D.
// Optional macro POT_HYST_EN: hysteresis on register updates (threshold HYST).
//
// state  | meaning
// IDLE   | parked, waits for en
// CMD_A  | issue wrt for the dummy (discarded) transaction
// WAIT_A | wait for done of the dummy transaction
// CMD_B  | issue wrt for the capturing transaction
// WAIT_B | wait for done, latch rd_data[11:0]
// STORE  | write the channel register, advance ch_idx
// GAP    | idle SCAN_GAP cycles between full scans
module pot_scan_ctrl #(
    parameter int CH_LP    = 1,
    parameter int CH_B1    = 0,
    parameter int CH_B2    = 4,
    parameter int CH_B3    = 2,
    parameter int CH_HP    = 3,
    parameter int CH_VOL   = 7,
    parameter int SCAN_GAP = 1024,
    parameter int HYST     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    pot_scan_ctrl_if.master   spi,
    output logic [11:0]       LP_gain,
    output logic [11:0]       B1_gain,
    output logic [11:0]       B2_gain,
    output logic [11:0]       B3_gain,
    output logic [11:0]       HP_gain,
    output logic [11:0]       VOLUME,
    output logic              scan_done
);

    typedef enum logic [2:0] {
        IDLE, CMD_A, WAIT_A, CMD_B, WAIT_B, STORE, GAP
    } state_t;

    localparam int GW = $clog2(SCAN_GAP + 1);

    state_t        state;
    logic [2:0]    ch_idx;
    logic [GW-1:0] gap_cnt;
    logic [11:0]   rd_q;
    logic          upd;

    function automatic logic [15:0] cmd_of(input logic [2:0] idx);
        logic [2:0] ch;
        case (idx)
            3'd0:    ch = 3'(CH_LP);
            3'd1:    ch = 3'(CH_B1);
            3'd2:    ch = 3'(CH_B2);
            3'd3:    ch = 3'(CH_B3);
            3'd4:    ch = 3'(CH_HP);
            default: ch = 3'(CH_VOL);
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

`ifdef POT_HYST_EN
    logic [5:0]         seen;
    logic [11:0]        cur;
    logic signed [12:0] diff;
    logic signed [12:0] mag;

    always_comb begin
        cur = LP_gain;
        case (ch_idx)
            3'd1:    cur = B1_gain;
            3'd2:    cur = B2_gain;
            3'd3:    cur = B3_gain;
            3'd4:    cur = HP_gain;
            3'd5:    cur = VOLUME;
            default: cur = LP_gain;
        endcase
        diff = $signed({1'b0, rd_q}) - $signed({1'b0, cur});
        mag  = (diff < 0) ? -diff : diff;
        // first store after reset always lands so the register leaves its preset
        upd  = !seen[ch_idx] || (mag > $signed(13'(HYST)));
    end
`else
    assign upd = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch_idx    <= 3'd0;
            gap_cnt   <= '0;
            rd_q      <= 12'h000;
            spi.wrt   <= 1'b0;
            spi.cmd   <= 16'h0000;
            scan_done <= 1'b0;
            LP_gain   <= 12'h800;
            B1_gain   <= 12'h800;
            B2_gain   <= 12'h800;
            B3_gain   <= 12'h800;
            HP_gain   <= 12'h800;
            VOLUME    <= 12'h000;
`ifdef POT_HYST_EN
            seen      <= 6'b0;
`endif
        end else begin
            spi.wrt   <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        ch_idx  <= 3'd0;
                        spi.cmd <= cmd_of(3'd0);
                        state   <= CMD_A;
                    end
                end
                CMD_A: begin
                    spi.wrt <= 1'b1;
                    state   <= WAIT_A;
                end
                WAIT_A: begin
                    if (spi.done) state <= CMD_B;
                end
                CMD_B: begin
                    spi.wrt <= 1'b1;
                    state   <= WAIT_B;
                end
                WAIT_B: begin
                    if (spi.done) begin
                        rd_q  <= spi.rd_data[11:0];
                        state <= STORE;
                    end
                end
                STORE: begin
                    if (upd) begin
                        case (ch_idx)
                            3'd0:    LP_gain <= rd_q;
                            3'd1:    B1_gain <= rd_q;
                            3'd2:    B2_gain <= rd_q;
                            3'd3:    B3_gain <= rd_q;
                            3'd4:    HP_gain <= rd_q;
                            default: VOLUME  <= rd_q;
                        endcase
                    end
`ifdef POT_HYST_EN
                    seen[ch_idx] <= 1'b1;
`endif
                    if (ch_idx < 3'd5) begin
                        ch_idx  <= ch_idx + 3'd1;
                        spi.cmd <= cmd_of(ch_idx + 3'd1);
                        state   <= CMD_A;
                    end else begin
                        ch_idx    <= 3'd0;
                        scan_done <= 1'b1;
                        gap_cnt   <= GW'(SCAN_GAP - 1);
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (en) begin
                            spi.cmd <= cmd_of(3'd0);
                            state   <= CMD_A;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pot_scan_ctrl.sv
// Self-checking bench for pot_scan_ctrl: ADC128S/SPI-master responder with
// random latency and values, plus a per-pot expected-register model.
module tb_pot_scan_ctrl;
    localparam int SCAN_GAP = 1024;
    localparam int HYST     = 4;
`ifdef POT_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic [11:0] LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, VOLUME;
    logic scan_done;

    pot_scan_ctrl_if sif ();

    pot_scan_ctrl #(.SCAN_GAP(SCAN_GAP), .HYST(HYST)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .spi(sif.master),
        .LP_gain(LP_gain), .B1_gain(B1_gain), .B2_gain(B2_gain),
        .B3_gain(B3_gain), .HP_gain(HP_gain), .VOLUME(VOLUME),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] adc [8];
    logic [11:0] exp_reg [6];
    bit   [5:0]  seen;
    bit          phase;
    int          dur_sum = 0;
    logic [15:0] cmd_log [$];

    int wrt_count = 0, wrt_double = 0, sd_count = 0;
    bit prev_wrt = 1'b0;
    int sd_cyc [$];
    int sd_dur [$];

    // pot order in a scan and which A2D channel each pot sits on
    int seq_ch [6] = '{1, 0, 4, 2, 3, 7};

    function automatic int slot_of(input int ch);
        for (int s = 0; s < 6; s++) if (seq_ch[s] == ch) return s;
        return 0;
    endfunction

    function automatic logic [11:0] get_reg(input int s);
        case (s)
            0: return LP_gain;
            1: return B1_gain;
            2: return B2_gain;
            3: return B3_gain;
            4: return HP_gain;
            default: return VOLUME;
        endcase
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 5; s++) exp_reg[s] = 12'h800;
        exp_reg[5] = 12'h000;
        seen  = '0;
        phase = 1'b0;
    endtask

    task automatic model_store(input int ch, input logic [11:0] v);
        int s, d;
        s = slot_of(ch);
        d = int'(v) - int'(exp_reg[s]);
        if (d < 0) d = -d;
        if (!HYST_ON || !seen[s] || d > HYST) exp_reg[s] = v;
        seen[s] = 1'b1;
    endtask

    task automatic randomize_adc();
        for (int c = 0; c < 8; c++) adc[c] = 12'($urandom_range(0, 12'h3F0));
    endtask

    // SPI master + ADC128S responder: every second transaction of a pair carries data
    initial begin
        logic [15:0] w;
        int ch, dly;
        sif.done = 1'b0;
        sif.rd_data = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (sif.wrt === 1'b1) begin
                w = sif.cmd;
                cmd_log.push_back(w);
                ch = int'(w[13:11]);
                dly = $urandom_range(1, 6);
                repeat (dly) @(posedge clk);
                #1;
                sif.done = 1'b1;
                sif.rd_data = {4'($urandom), adc[ch]};
                if (rst_n) begin
                    dur_sum += dly + 1;
                    if (phase) model_store(ch, adc[ch]);
                    phase = !phase;
                end
                @(posedge clk); #1;
                sif.done = 1'b0;
                sif.rd_data = 16'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (sif.wrt === 1'b1) begin
                wrt_count++;
                if (prev_wrt) wrt_double++;
            end
            prev_wrt = (sif.wrt === 1'b1);
            if (scan_done === 1'b1) begin
                sd_count++;
                sd_cyc.push_back(cyc);
                sd_dur.push_back(dur_sum);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

    task automatic wait_sd(input int budget, output bit ok);
        int start;
        start = sd_count;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (sd_count != start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int snap;
        rst_n = 1'b0;
        en = 1'b0;
        randomize_adc();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (get_reg(s) !== exp_reg[s]) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h, required %h", s, get_reg(s), exp_reg[s]);
            end
        end
        n_checks++;
        if (sif.wrt !== 1'b0 || scan_done !== 1'b0 || sif.cmd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_ctl: got wrt=%b scan_done=%b cmd=%h, required 0 0 0000",
                     sif.wrt, scan_done, sif.cmd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        snap = wrt_count;
        repeat (10000) @(negedge clk);
        n_checks++;
        if (wrt_count != snap) begin
            n_fail++;
            $display("FAIL idle_no_wrt: got %0d wrt pulses, required 0", wrt_count - snap);
        end
    endtask

    task automatic test_first_scan();
        bit ok;
        int start;
        randomize_adc();
        adc[1] = 12'h123;
        cmd_log.delete();
        start = sd_count;
        en = 1'b1;
        wait_sd(4000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL first_scan_timeout: got no scan_done, required one within 4000 cycles");
        end
        n_checks++;
        if (cmd_log.size() != 12) begin
            n_fail++;
            $display("FAIL first_scan_len: got %0d transactions, required 12", cmd_log.size());
        end
        for (int i = 0; i < 12 && i < cmd_log.size(); i++) begin
            n_checks++;
            if (cmd_log[i] !== {2'b00, 3'(seq_ch[i/2]), 11'h000}) begin
                n_fail++;
                $display("FAIL first_scan_cmd%0d: got %h, required %h", i, cmd_log[i],
                         {2'b00, 3'(seq_ch[i/2]), 11'h000});
            end
        end
        n_checks++;
        if (LP_gain !== 12'h123) begin
            n_fail++;
            $display("FAIL first_scan_lp: got %h, required 123", LP_gain);
        end
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (get_reg(s) !== exp_reg[s]) begin
                n_fail++;
                $display("FAIL first_scan_reg%0d: got %h, required %h", s, get_reg(s), exp_reg[s]);
            end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (sd_count != start + 1 || wrt_double != 0) begin
            n_fail++;
            $display("FAIL first_scan_pulses: got scan_done=%0d double_wrt=%0d, required 1 0",
                     sd_count - start, wrt_double);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n, got, req;
        for (int k = 0; k < 2; k++) begin
            randomize_adc();
            wait_sd(SCAN_GAP + 2000, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL b2b_timeout%0d: got no scan_done, required one", k);
            end
            for (int s = 0; s < 6; s++) begin
                n_checks++;
                if (get_reg(s) !== exp_reg[s]) begin
                    n_fail++;
                    $display("FAIL b2b_reg%0d_%0d: got %h, required %h", k, s, get_reg(s), exp_reg[s]);
                end
            end
            n = sd_cyc.size();
            if (n >= 2) begin
                got = sd_cyc[n-1] - sd_cyc[n-2];
                req = SCAN_GAP + 18 + (sd_dur[n-1] - sd_dur[n-2]);
                n_checks++;
                if (got != req) begin
                    n_fail++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, required %0d", k, got, req);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        bit ok, hit;
        int snap, sds;
        randomize_adc();
        hit = 1'b0;
        for (int i = 0; i < SCAN_GAP + 3000; i++) begin
            @(negedge clk);
            if (sif.wrt === 1'b1 && sif.cmd[13:11] == 3'd4) begin
                hit = 1'b1;
                break;
            end
        end
        en = 1'b0;
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL en_drop_b2: got no B2 transaction, required one");
        end
        wait_sd(3000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL en_drop_finish: got no scan_done, required scan to complete");
        end
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (get_reg(s) !== exp_reg[s]) begin
                n_fail++;
                $display("FAIL en_drop_reg%0d: got %h, required %h", s, get_reg(s), exp_reg[s]);
            end
        end
        snap = wrt_count;
        sds = sd_count;
        repeat (SCAN_GAP + 500) @(negedge clk);
        n_checks++;
        if (wrt_count != snap || sd_count != sds) begin
            n_fail++;
            $display("FAIL en_drop_parked: got %0d wrt %0d scan_done, required 0 0",
                     wrt_count - snap, sd_count - sds);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int hp;
        randomize_adc();
        hp = 0;
        en = 1'b1;
        for (int i = 0; i < 4000 && hp < 2; i++) begin
            @(posedge clk); #1;
            if (sif.wrt === 1'b1 && sif.cmd[13:11] == 3'd3) hp++;
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (hp != 2) begin
            n_fail++;
            $display("FAIL rst_mid_reach: got %0d HP transactions, required 2", hp);
        end
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (get_reg(s) !== exp_reg[s]) begin
                n_fail++;
                $display("FAIL rst_mid_reg%0d: got %h, required %h", s, get_reg(s), exp_reg[s]);
            end
        end
        n_checks++;
        if (sif.wrt !== 1'b0 || scan_done !== 1'b0 || sif.cmd !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_mid_ctl: got wrt=%b scan_done=%b cmd=%h, required 0 0 0000",
                     sif.wrt, scan_done, sif.cmd);
        end
        repeat (10) @(posedge clk);
        #1;
        cmd_log.delete();
        rst_n = 1'b1;
        wait_sd(4000, ok);
        n_checks++;
        if (!ok || cmd_log.size() != 12) begin
            n_fail++;
            $display("FAIL rst_mid_rescan: got done=%b with %0d transactions, required 1 with 12",
                     ok, cmd_log.size());
        end
        n_checks++;
        if (cmd_log.size() == 0 || cmd_log[0] !== 16'h0800) begin
            n_fail++;
            $display("FAIL rst_mid_first_cmd: got %h, required 0800",
                     (cmd_log.size() == 0) ? 16'hxxxx : cmd_log[0]);
        end
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (get_reg(s) !== exp_reg[s]) begin
                n_fail++;
                $display("FAIL rst_mid_scan_reg%0d: got %h, required %h", s, get_reg(s), exp_reg[s]);
            end
        end
    endtask

    task automatic test_hyst();
        bit ok;
        logic [11:0] vals [3];
        logic [11:0] want [3];
        vals = '{12'h400, 12'h403, 12'h405};
        want = '{12'h400, (HYST_ON ? 12'h400 : 12'h403), 12'h405};
        for (int k = 0; k < 3; k++) begin
            adc[7] = vals[k];
            wait_sd(SCAN_GAP + 2000, ok);
            n_checks++;
            if (!ok || VOLUME !== want[k]) begin
                n_fail++;
                $display("FAIL hyst_step%0d: got done=%b VOLUME=%h, required 1 %h", k, ok, VOLUME, want[k]);
            end
            n_checks++;
            if (VOLUME !== exp_reg[5]) begin
                n_fail++;
                $display("FAIL hyst_model%0d: got %h, required %h", k, VOLUME, exp_reg[5]);
            end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_back_to_back();
        test_en_drop();
        test_reset_mid();
        test_hyst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
